// File: rtl/fmul_pkg.sv
// Shared types and constants for the single-precision multiplier.
package fmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    MUL,
    NORM,
    DONE
  } state_t;

  localparam int          BIAS     = 127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int          EXP_MAX  = 255;
  localparam int          MUL_ITER = 24;

  typedef struct packed {
    logic zero;
    logic denorm;
    logic inf;
    logic nan;
  } fclass_t;

endpackage

// File: rtl/fmul_classify.sv
// Combinational operand classifier: zero / denormal / Inf / NaN flags.
module fmul_classify
  import fmul_pkg::*;
(
  input  logic [31:0] op,
  output fclass_t     cls
);

  logic [7:0]  e;
  logic [22:0] f;

  assign e = op[30:23];
  assign f = op[22:0];

  always_comb begin
    cls        = '0;
    cls.zero   = (e == 8'h00) && (f == 23'h0);
    cls.denorm = (e == 8'h00) && (f != 23'h0);
    cls.inf    = (e == 8'hFF) && (f == 23'h0);
    cls.nan    = (e == 8'hFF) && (f != 23'h0);
  end

endmodule

// File: rtl/float_mul_unit.sv
// Multi-cycle IEEE754 single multiplier (24-cycle shift-add, flush-to-zero).
// Define FMUL_RNE_EN for round-to-nearest-even; default build truncates.
module float_mul_unit
  import fmul_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] data1_in,
  input  logic [31:0] data2_in,
  input  logic        trig,
  output logic [31:0] result_out,
  output logic        result_vld,
  output logic        busy
);

  localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);
  localparam logic signed [9:0] BIAS_S    = 10'(BIAS);

  state_t             state;
  logic [31:0]        op_a, op_b;
  logic               sign;
  logic signed [9:0]  exp_r;
  logic [23:0]        man_a, man_b;
  logic [47:0]        prod;
  logic [4:0]         cnt;

  fclass_t cls_a, cls_b;

  fmul_classify u_cls_a (.op(op_a), .cls(cls_a));
  fmul_classify u_cls_b (.op(op_b), .cls(cls_b));

  logic              sign_c;
  logic signed [9:0] exp_c;
  logic              spec_hit;
  logic [31:0]       spec_val;
  logic              za, zb;

  assign sign_c = op_a[31] ^ op_b[31];
  assign exp_c  = $signed({2'b00, op_a[30:23]}) + $signed({2'b00, op_b[30:23]}) - BIAS_S;
  // Denormals behave exactly like zeros, including for Inf x zero.
  assign za     = cls_a.zero | cls_a.denorm;
  assign zb     = cls_b.zero | cls_b.denorm;

  always_comb begin
    spec_hit = 1'b1;
    spec_val = QNAN;
    if (cls_a.nan || cls_b.nan)                       spec_val = QNAN;
    else if ((cls_a.inf && zb) || (cls_b.inf && za))  spec_val = QNAN;
    else if (cls_a.inf || cls_b.inf)                  spec_val = {sign_c, 8'hFF, 23'h0};
    else if (za || zb)                                spec_val = {sign_c, 31'h0};
    else begin
      spec_hit = 1'b0;
      spec_val = '0;
    end
  end

  logic [22:0]       mant, mant_f;
  logic signed [9:0] exp_n, exp_f;
  logic [24:0]       sig_r;
  logic              inc;
  logic [31:0]       norm_val;
`ifdef FMUL_RNE_EN
  logic              g, r, s;
`endif

  always_comb begin
    if (prod[47]) begin
      mant  = prod[46:24];
      exp_n = exp_r + 10'sd1;
    end else begin
      mant  = prod[45:23];
      exp_n = exp_r;
    end
`ifdef FMUL_RNE_EN
    if (prod[47]) begin
      g = prod[23];
      r = prod[22];
      s = |prod[21:0];
    end else begin
      g = prod[22];
      r = prod[21];
      s = |prod[20:0];
    end
    inc = g & (r | s | mant[0]);
`else
    inc = 1'b0;
`endif
    sig_r = {2'b01, mant} + {24'd0, inc};
    // Round carry turns 1.111..1 into 10.000..0: renormalise by one.
    if (sig_r[24]) begin
      mant_f = sig_r[23:1];
      exp_f  = exp_n + 10'sd1;
    end else begin
      mant_f = sig_r[22:0];
      exp_f  = exp_n;
    end
    if (exp_f >= EXP_MAX_S)   norm_val = {sign, 8'hFF, 23'h0};
    else if (exp_f <= 10'sd0) norm_val = {sign, 31'h0};
    else                      norm_val = {sign, exp_f[7:0], mant_f};
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      sign       <= 1'b0;
      exp_r      <= '0;
      man_a      <= '0;
      man_b      <= '0;
      prod       <= '0;
      cnt        <= '0;
      result_out <= '0;
      result_vld <= 1'b0;
      busy       <= 1'b0;
    end else begin
      result_vld <= 1'b0;
      case (state)
        IDLE: if (trig) begin
          op_a  <= data1_in;
          op_b  <= data2_in;
          busy  <= 1'b1;
          state <= CLASSIFY;
        end
        CLASSIFY: begin
          sign  <= sign_c;
          exp_r <= exp_c;
          man_a <= {1'b1, op_a[22:0]};
          man_b <= {1'b1, op_b[22:0]};
          prod  <= '0;
          cnt   <= '0;
          if (spec_hit) begin
            result_out <= spec_val;
            result_vld <= 1'b1;
            state      <= DONE;
          end else begin
            state <= MUL;
          end
        end
        MUL: begin
          prod <= prod + (man_b[cnt] ? (48'(man_a) << cnt) : 48'd0);
          if (cnt == 5'(MUL_ITER - 1)) state <= NORM;
          else                         cnt   <= cnt + 5'd1;
        end
        NORM: begin
          result_out <= norm_val;
          result_vld <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_mul_unit.sv
// Scoreboard bench for float_mul_unit: directed vectors, latency and busy checks.
module tb_float_mul_unit;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] data1_in = '0;
  logic [31:0] data2_in = '0;
  logic        trig = 1'b0;
  logic [31:0] result_out;
  logic        result_vld;
  logic        busy;

  float_mul_unit dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data1_in  (data1_in),
    .data2_in  (data2_in),
    .trig      (trig),
    .result_out(result_out),
    .result_vld(result_vld),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          at;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

`ifdef FMUL_RNE_EN
  localparam logic [31:0] RND_WANT = 32'h3FC0_0002;
`else
  localparam logic [31:0] RND_WANT = 32'h3FC0_0001;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %08h want %08h", nm, act, want);
  endtask

  // Monitor: every result_vld pulse must match the oldest expectation, value and cycle.
  exp_t mon_e;
  always @(negedge sys_clk) begin
    if (result_vld === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_vld: got result %08h at cycle %0d, want no pulse", result_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.nm, "_value"}, result_out, mon_e.val);
        check({mon_e.nm, "_cycle"}, 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL wait_idle: timeout busy=%b pending=%0d, want idle", busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input int lat);
    wait_idle();
    @(negedge sys_clk);
    data1_in = a;
    data2_in = b;
    trig     = 1'b1;
    sb.push_back('{want, cyc + lat, nm});
    @(negedge sys_clk);
    trig = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_result_out", result_out, 32'h0);
    check("rst_result_vld", {31'h0, result_vld}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1.5 x 2.0 with busy profile over cycles 0..28
    @(negedge sys_clk);
    data1_in = 32'h3FC0_0000;
    data2_in = 32'h4000_0000;
    trig     = 1'b1;
    e        = cyc;
    sb.push_back('{32'h4040_0000, e + 27, "mul_1p5x2"});
    for (int c = 0; c <= 28; c++) begin
      if (c > 0) @(negedge sys_clk);
      if (c == 1) trig = 1'b0;
      check($sformatf("busy_c%0d", c), {31'h0, busy}, {31'h0, (c >= 1 && c <= 27)});
    end

    run_vec("neg2x3",       32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 27);
    run_vec("inf_x_zero",   32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 2);
    run_vec("ovf",          32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 27);
    run_vec("neg_ovf",      32'hFF00_0000, 32'h7F00_0000, 32'hFF80_0000, 27);
    run_vec("unf",          32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 27);
    run_vec("neg_unf",      32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 27);
    run_vec("denorm",       32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 2);
    run_vec("round",        32'h3F80_0001, 32'h3FC0_0000, RND_WANT,      27);
    run_vec("one_x_one",    32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 27);
    run_vec("1p5sq",        32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 27);
    run_vec("nan_x_one",    32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, 2);
    run_vec("inf_x_neg2",   32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 2);
    run_vec("negzero_x5",   32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 2);
    run_vec("inf_x_negz",   32'h7F80_0000, 32'h8000_0000, 32'h7FC0_0000, 2);
    run_vec("denorm_x_inf", 32'h0000_0010, 32'hFF80_0000, 32'h7FC0_0000, 2);

    // Reset at MUL cycle 10 aborts with no pulse
    wait_idle();
    @(negedge sys_clk);
    data1_in = 32'h3FC0_0000;
    data2_in = 32'h4000_0000;
    trig     = 1'b1;
    e        = cyc;
    @(negedge sys_clk);
    trig = 1'b0;
    while (cyc < e + 12) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check("abort_result_out", result_out, 32'h0);
    check("abort_result_vld", {31'h0, result_vld}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge sys_clk);
    check("abort_busy_later", {31'h0, busy}, 32'h0);
    run_vec("after_abort", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 27);

    // trig held high: one result every 28 cycles
    wait_idle();
    @(negedge sys_clk);
    data1_in = 32'h4000_0000;
    data2_in = 32'h4040_0000;
    trig     = 1'b1;
    e        = cyc;
    for (int k = 0; k < 3; k++)
      sb.push_back('{32'h40C0_0000, e + 27 + 28 * k, $sformatf("held_%0d", k)});
    repeat (60) @(negedge sys_clk);
    trig = 1'b0;

    // trig pulses while busy (including in DONE) are ignored
    wait_idle();
    @(negedge sys_clk);
    data1_in = 32'h3FC0_0000;
    data2_in = 32'h4000_0000;
    trig     = 1'b1;
    e        = cyc;
    sb.push_back('{32'h4040_0000, e + 27, "busy_pulses"});
    for (int c = 1; c <= 28; c++) begin
      @(negedge sys_clk);
      trig = (c == 5 || c == 20 || c == 27);
    end
    trig = 1'b0;
    repeat (40) @(negedge sys_clk);
    check("busy_pulses_idle", {31'h0, busy}, 32'h0);

    wait_idle();
    repeat (5) @(negedge sys_clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/float_mul_unit.md
FLOAT_MUL_UNIT -- requirements
Module: float_mul_unit

Interface
REQ-001 The block SHALL have these ports:
sys_clk  in  1  single clock; all state changes on rising edge.
sys_rst_n  in  1  reset, synchronous, active-low.
data1_in  in  32  operand A, IEEE754 single.
data2_in  in  32  operand B, IEEE754 single.
trig  in  1  start request, sampled only in IDLE.
result_out  out  32  product, registered, held until next result.
result_vld  out  1  one-cycle pulse, result_out valid.
busy  out  1  high in every state except IDLE.

Function
REQ-002 The block SHALL implement states IDLE, CLASSIFY, MUL, NORM, DONE, in that order.
REQ-003 In IDLE with trig=1 it SHALL capture data1_in/data2_in and go to CLASSIFY; in any other state trig SHALL be ignored.
REQ-004 CLASSIFY SHALL set sign = A[31]^B[31], exp = eA+eB-127 (10-bit signed), and mantissas {1,frac}; then go to MUL, or go to DONE when special (REQ-009).
REQ-005 MUL SHALL run an unsigned 24x24 shift-add for exactly 24 cycles into a 48-bit product, with a 5-bit iteration counter cleared on entry.
REQ-006 NORM (1 cycle) SHALL: if product[47]=1, take mantissa from [46:24] and set exp+1; else take [45:23]; then round (REQ-013/014); if rounding carries out of the mantissa, shift right and set exp+1.
REQ-007 After NORM, exp>=255 SHALL give ±Inf ({sign,8'hFF,23'h0}) and exp<=0 SHALL give signed zero (flush, no denormal output).
REQ-008 DONE SHALL drive result_vld=1 for exactly one cycle, update result_out in the same cycle, then return to IDLE; a trig in DONE SHALL be ignored.
REQ-009 Special cases, in priority order, resolved in CLASSIFY: any NaN -> 0x7FC00000; Inf x zero -> 0x7FC00000; any Inf -> signed Inf; any zero -> signed zero.
REQ-010 Denormal inputs (exp=0, frac!=0) SHALL be treated as signed zero.
REQ-011 Latency: for normal operands with trig sampled at cycle 0, result_vld SHALL be high at cycle 27; for special cases, at cycle 2.
REQ-012 result_out SHALL keep its last value while result_vld=0; busy SHALL be deasserted in the cycle after DONE.

Configuration
REQ-013 With FMUL_RNE_EN defined, NORM SHALL round to nearest, ties to even, using guard, round and sticky (OR of all lower product bits).
REQ-014 Without FMUL_RNE_EN, NORM SHALL truncate the discarded bits; latency SHALL be identical in both builds.

Reset
REQ-015 With sys_rst_n=0 at a clock edge: state=IDLE, result_out=0, result_vld=0, busy=0, counter=0, and the operand/product registers = 0.
REQ-016 A reset asserted in any state, including mid-MUL, SHALL abort the operation with no result_vld pulse; the first trig after release SHALL start a clean operation.

Structure
REQ-017 Shared package fmul_pkg SHALL hold the state enum and the constants BIAS=127, QNAN=32'h7FC00000, EXP_MAX=255 and MUL_ITER=24.
REQ-018 Operand classification (zero/denormal/Inf/NaN flags per operand) SHALL be a combinational sub-module fmul_classify, instantiated twice.

Verification
REQ-019 0x3FC00000 x 0x40000000, trig at cycle 0 -> result_vld at cycle 27, result_out=0x40400000; busy high cycles 1-27.
REQ-020 0xC0000000 x 0x40400000 -> 0xC0C00000; then 0x7F800000 x 0x00000000 -> 0x7FC00000 with result_vld at cycle 2.
REQ-021 0x7F000000 x 0x7F000000 -> 0x7F800000; 0x00800000 x 0x00800000 -> 0x00000000; 0x00000001 x 0x3F800000 -> 0x00000000.
REQ-022 0x3F800001 x 0x3FC00000 -> 0x3FC00002 with FMUL_RNE_EN, 0x3FC00001 without.
REQ-023 sys_rst_n=0 at MUL cycle 10 -> no result_vld, result_out=0, busy=0; a new trig with 0x3FC00000 x 0x40000000 -> 0x40400000 at +27 cycles.
REQ-024 trig held high continuously -> exactly one result every 28 cycles; trig pulses during busy produce no extra results.
